// File: rtl/soc_uart_pkg.sv
// Shared UART definitions: RX FIFO sizing, the empty-read word and the byte type.
package soc_uart_pkg;

    localparam int UART_RX_FIFO_DEPTH = 16;
    localparam logic [31:0] UART_RX_EMPTY_WORD = 32'hFFFF_FFFF;

    typedef logic [7:0] uart_byte_t;

endpackage

// File: rtl/uart_rx_fifo_mem.sv
// UART RX FIFO storage: DEPTH x 8 register array, synchronous write, asynchronous read.
module uart_rx_fifo_mem
    import soc_uart_pkg::*;
#(
    parameter int DEPTH = UART_RX_FIFO_DEPTH,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  uart_byte_t    wdata,
    input  logic [AW-1:0] raddr,
    output uart_byte_t    rdata
);

    uart_byte_t mem [DEPTH];

    // Write the accepted byte; storage is never reset, emptiness is tracked by the controller.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Head byte is visible immediately from the read pointer (fall-through).
    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_rx_fifo.sv
// UART RX FIFO: first-word-fall-through byte buffer with fill-level IRQ and sticky overflow.
//
// Handshake: in_valid and data_rd are single-cycle strobes with no backpressure.
// A byte offered while full (and not matched by an accepted pop) is dropped and
// flagged in overflow; a pop while empty is ignored. clear beats both strobes.
module uart_rx_fifo
    import soc_uart_pkg::*;
#(
    parameter int DEPTH     = UART_RX_FIFO_DEPTH,
    parameter int THRESHOLD = 1
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     in_valid,
    input  logic [7:0]               in_data,
    input  logic                     data_rd,
    input  logic                     clear,
    output logic [31:0]              data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     overflow,
    output logic                     rx_irq
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          empty;
    logic          pop_ok;
    logic          push_ok;
    logic          drop;
    uart_byte_t    head_byte;

    // Accept decisions from the current fill level; a pop frees a slot for a same-cycle push.
    always_comb begin
        empty   = (count == '0);
        pop_ok  = data_rd && !empty;
        push_ok = in_valid && (!full || pop_ok);
        drop    = in_valid && full && !pop_ok;
    end

    // Pointers, fill counter and sticky overflow; clear wins over any push or pop.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clear) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            if (drop) begin
                overflow <= 1'b1;
            end
        end
    end

    uart_rx_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok && !clear),
        .waddr (wr_ptr),
        .wdata (in_data),
        .raddr (rd_ptr),
        .rdata (head_byte)
    );

    // Status flags and head word, all combinational from registered state.
    always_comb begin
        full   = (count == CW'(DEPTH));
        rx_irq = (count >= CW'(THRESHOLD));
        data   = empty ? UART_RX_EMPTY_WORD : {24'h0, head_byte};
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed self-checking bench for uart_rx_fifo (DEPTH=16, THRESHOLD=4).
module tb_uart_rx_fifo;

    logic        clk;
    logic        resetn;
    logic        in_valid;
    logic [7:0]  in_data;
    logic        data_rd;
    logic        clear;
    logic [31:0] data;
    logic [4:0]  count;
    logic        full;
    logic        overflow;
    logic        rx_irq;

    int checks   = 0;
    int failures = 0;
    logic [7:0] exp_q[$];

    uart_rx_fifo #(
        .DEPTH     (16),
        .THRESHOLD (4)
    ) dut (
        .clk      (clk),
        .resetn   (resetn),
        .in_valid (in_valid),
        .in_data  (in_data),
        .data_rd  (data_rd),
        .clear    (clear),
        .data     (data),
        .count    (count),
        .full     (full),
        .overflow (overflow),
        .rx_irq   (rx_irq)
    );

    // Clock and watchdog
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Driver tasks: inputs change 1ns after a rising edge, outputs sampled there too.
    task automatic cycle(input logic v, input logic [7:0] b, input logic rd, input logic clr);
        in_valid = v;
        in_data  = b;
        data_rd  = rd;
        clear    = clr;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        data_rd  = 1'b0;
        clear    = 1'b0;
    endtask

    task automatic push(input logic [7:0] b);
        cycle(1'b1, b, 1'b0, 1'b0);
    endtask

    task automatic pop();
        cycle(1'b0, 8'h00, 1'b1, 1'b0);
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", count); end
        checks++; if (data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL reset_data got=%h exp=ffffffff", data); end
        checks++; if (full !== 1'b0) begin failures++; $display("FAIL reset_full got=%b exp=0", full); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL reset_overflow got=%b exp=0", overflow); end
        checks++; if (rx_irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%b exp=0", rx_irq); end
        resetn = 1'b1;
    endtask

    task automatic test_basic();
        push(8'h41);
        push(8'h42);
        checks++; if (data !== 32'h0000_0041) begin failures++; $display("FAIL basic_head got=%h exp=00000041", data); end
        checks++; if (count !== 5'd2) begin failures++; $display("FAIL basic_count2 got=%0d exp=2", count); end
        checks++; if (rx_irq !== 1'b0) begin failures++; $display("FAIL basic_irq got=%b exp=0", rx_irq); end
        pop();
        checks++; if (data !== 32'h0000_0042) begin failures++; $display("FAIL basic_pop1 got=%h exp=00000042", data); end
        pop();
        checks++; if (data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL basic_pop2 got=%h exp=ffffffff", data); end
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL basic_count0 got=%0d exp=0", count); end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 17; i++) push(8'(i));
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL ovf_full got=%b exp=1", full); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", overflow); end
        checks++; if (count !== 5'd16) begin failures++; $display("FAIL ovf_count got=%0d exp=16", count); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (data !== {24'h0, 8'(i)}) begin
                failures++; $display("FAIL ovf_order[%0d] got=%h exp=%h", i, data, {24'h0, 8'(i)});
            end
            pop();
        end
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL ovf_drained got=%0d exp=0", count); end
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL ovf_sticky got=%b exp=1", overflow); end
    endtask

    task automatic test_full_push_pop_wrap();
        cycle(1'b0, 8'h00, 1'b0, 1'b1);
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL wrap_clear_ovf got=%b exp=0", overflow); end
        exp_q.delete();
        for (int i = 0; i < 16; i++) begin
            push(8'h20 + 8'(i));
            exp_q.push_back(8'h20 + 8'(i));
        end
        checks++; if (full !== 1'b1) begin failures++; $display("FAIL wrap_full got=%b exp=1", full); end
        cycle(1'b1, 8'hAA, 1'b1, 1'b0);
        void'(exp_q.pop_front());
        exp_q.push_back(8'hAA);
        checks++; if (count !== 5'd16) begin failures++; $display("FAIL wrap_full_pp_count got=%0d exp=16", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL wrap_full_pp_ovf got=%b exp=0", overflow); end
        checks++; if (data !== 32'h0000_0021) begin failures++; $display("FAIL wrap_full_pp_head got=%h exp=00000021", data); end
        for (int i = 0; i < 40; i++) begin
            checks++;
            if (data !== {24'h0, exp_q[0]}) begin
                failures++; $display("FAIL wrap_pp[%0d] got=%h exp=%h", i, data, {24'h0, exp_q[0]});
            end
            if (i == 14) begin
                checks++;
                if (exp_q[1] !== 8'hAA || data !== 32'h0000_002F) begin
                    failures++; $display("FAIL wrap_aa_last got=%h exp=0000002f", data);
                end
            end
            cycle(1'b1, 8'h60 + 8'(i), 1'b1, 1'b0);
            void'(exp_q.pop_front());
            exp_q.push_back(8'h60 + 8'(i));
        end
        checks++; if (count !== 5'd16) begin failures++; $display("FAIL wrap_count got=%0d exp=16", count); end
        for (int i = 0; i < 16; i++) begin
            checks++;
            if (data !== {24'h0, exp_q[0]}) begin
                failures++; $display("FAIL wrap_drain[%0d] got=%h exp=%h", i, data, {24'h0, exp_q[0]});
            end
            void'(exp_q.pop_front());
            pop();
        end
        checks++; if (data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL wrap_empty got=%h exp=ffffffff", data); end
    endtask

    task automatic test_empty_push_pop();
        cycle(1'b1, 8'h55, 1'b1, 1'b0);
        checks++; if (count !== 5'd1) begin failures++; $display("FAIL empty_pp_count got=%0d exp=1", count); end
        checks++; if (data !== 32'h0000_0055) begin failures++; $display("FAIL empty_pp_data got=%h exp=00000055", data); end
        pop();
        pop();
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL empty_pop_count got=%0d exp=0", count); end
        checks++; if (data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL empty_pop_data got=%h exp=ffffffff", data); end
        checks++; if (overflow !== 1'b0 || full !== 1'b0) begin failures++; $display("FAIL empty_pop_flags got=%b%b exp=00", overflow, full); end
        push(8'h77);
        checks++; if (data !== 32'h0000_0077) begin failures++; $display("FAIL empty_ptr_sync got=%h exp=00000077", data); end
        pop();
    endtask

    task automatic test_threshold_clear();
        for (int i = 1; i <= 3; i++) push(8'(i));
        checks++; if (rx_irq !== 1'b0) begin failures++; $display("FAIL thr_below got=%b exp=0", rx_irq); end
        push(8'h04);
        checks++; if (rx_irq !== 1'b1) begin failures++; $display("FAIL thr_rise got=%b exp=1", rx_irq); end
        push(8'h05);
        pop();
        checks++; if (rx_irq !== 1'b1) begin failures++; $display("FAIL thr_at4 got=%b exp=1", rx_irq); end
        pop();
        checks++; if (rx_irq !== 1'b0 || count !== 5'd3) begin failures++; $display("FAIL thr_fall got=%b/%0d exp=0/3", rx_irq, count); end
        for (int i = 0; i < 14; i++) push(8'h80 + 8'(i));
        checks++; if (overflow !== 1'b1) begin failures++; $display("FAIL thr_ovf got=%b exp=1", overflow); end
        cycle(1'b1, 8'hEE, 1'b1, 1'b1);
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL clr_count got=%0d exp=0", count); end
        checks++; if (overflow !== 1'b0) begin failures++; $display("FAIL clr_ovf got=%b exp=0", overflow); end
        checks++; if (data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL clr_data got=%h exp=ffffffff", data); end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) push(8'hC0 + 8'(i));
        checks++; if (count !== 5'd5) begin failures++; $display("FAIL ares_pre got=%0d exp=5", count); end
        #2;
        resetn = 1'b0;
        #1;
        checks++; if (count !== 5'd0) begin failures++; $display("FAIL ares_count got=%0d exp=0", count); end
        checks++; if (data !== 32'hFFFF_FFFF) begin failures++; $display("FAIL ares_data got=%h exp=ffffffff", data); end
        @(posedge clk);
        #1;
        resetn = 1'b1;
        push(8'h99);
        checks++; if (data !== 32'h0000_0099 || count !== 5'd1) begin failures++; $display("FAIL ares_first_push got=%h/%0d exp=00000099/1", data, count); end
    endtask

    // Test sequence and final report
    initial begin
        resetn   = 1'b0;
        in_valid = 1'b0;
        in_data  = 8'h00;
        data_rd  = 1'b0;
        clear    = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_basic();
        test_overflow();
        test_full_push_pop_wrap();
        test_empty_push_pop();
        test_threshold_clear();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
